// File: rtl/counter_ctrl.sv
// Programmable interval timer controller: accepts (limit, mode) over valid/ready,
// runs an up-counter 0..limit and pulses tick at the terminal count.
module counter_ctrl #(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              syn_n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N_BITS-1:0] cmd_limit,
  input  logic              cmd_periodic,
  input  logic              pause,
  input  logic              abort,
  output logic [N_BITS-1:0] count,
  output logic              busy,
  output logic              tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

  state_t            state_reg, state_next;
  logic [N_BITS-1:0] count_reg, count_next;
  logic [N_BITS-1:0] limit_reg, limit_next;
  logic              periodic_reg, periodic_next;
  logic              tick_reg, tick_next;
  logic              busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (!syn_n_rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      limit_reg    <= '0;
      periodic_reg <= 1'b0;
      tick_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      limit_reg    <= limit_next;
      periodic_reg <= periodic_next;
      tick_reg     <= tick_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    limit_next    = limit_reg;
    periodic_next = periodic_reg;
    tick_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          limit_next    = cmd_limit;
          periodic_next = cmd_periodic;
          count_next    = '0;
          state_next    = RUN;
        end
      end
      RUN: begin
        // abort beats pause, and pause beats the terminal-count check
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (pause) begin
          state_next = HOLD;
        end else if (count_reg == limit_reg) begin
          tick_next = 1'b1;
          if (periodic_reg) begin
            count_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          count_next = count_reg + ONE;
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign cmd_ready = (state_reg == IDLE);
  assign count     = count_reg;
  assign busy      = busy_reg;
  assign tick      = tick_reg;

endmodule
